// File: rtl/vga_pixel_fifo.sv
// rtl/vga_pixel_fifo.sv - RGB565 pixel FIFO feeding the VGA colour/timing stage
module vga_pixel_fifo #(
    parameter int P_DEPTH  = 1024,
    parameter int P_ADDR_W = 10
) (
    input  logic                I_clk,
    input  logic                I_rst_n,
    input  logic                I_wr_valid,
    input  logic [15:0]         I_wr_data,
    output logic                O_wr_ready,
    input  logic                I_rd_en,
    input  logic                I_flush,
    input  logic                I_clr_err,
    output logic [4:0]          O_red,
    output logic [5:0]          O_green,
    output logic [4:0]          O_blue,
    output logic [P_ADDR_W:0]   O_level,
    output logic                O_empty,
    output logic                O_underflow
);

    localparam logic [P_ADDR_W:0] LP_FULL = (P_ADDR_W + 1)'(P_DEPTH);

    logic [15:0]         mem [P_DEPTH];
    logic [P_ADDR_W-1:0] wr_ptr;
    logic [P_ADDR_W-1:0] rd_ptr;
    logic [15:0]         pix_q;
    logic                out_of_rst;
    logic                wr_acc;
    logic                rd_acc;
    logic                rd_under;

    // Flush dominates: it blocks the write and turns any pop into a silent blank.
    assign O_empty    = (O_level == '0);
    assign O_wr_ready = out_of_rst && (O_level != LP_FULL) && !I_flush;
    assign wr_acc     = I_wr_valid && O_wr_ready;
    assign rd_acc     = I_rd_en && !O_empty && !I_flush;
    assign rd_under   = I_rd_en && O_empty && !I_flush;

    assign O_red   = pix_q[15:11];
    assign O_green = pix_q[10:5];
    assign O_blue  = pix_q[4:0];

    // Holds wr_ready low during reset and for the edge on which reset is released.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            out_of_rst <= 1'b0;
        end else begin
            out_of_rst <= 1'b1;
        end
    end

    // Pixel storage; contents need no reset since level gates every read.
    always_ff @(posedge I_clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= I_wr_data;
        end
    end

    // Pointers and fill level; pointers wrap naturally at P_DEPTH.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            O_level <= '0;
        end else if (I_flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            O_level <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_acc && !rd_acc) begin
                O_level <= O_level + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                O_level <= O_level - 1'b1;
            end
        end
    end

    // Registered colour: popped word, otherwise black (blanking, underflow, flush).
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            pix_q <= 16'h0000;
        end else if (rd_acc) begin
            pix_q <= mem[rd_ptr];
        end else begin
            pix_q <= 16'h0000;
        end
    end

    // Sticky underflow; a new empty pop wins over a same-cycle clear.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_underflow <= 1'b0;
        end else if (rd_under) begin
            O_underflow <= 1'b1;
        end else if (I_clr_err) begin
            O_underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// tb/tb_vga_pixel_fifo.sv - self-checking bench for vga_pixel_fifo
module tb_vga_pixel_fifo;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          I_clk = 1'b0;
    logic          I_rst_n = 1'b0;
    logic          I_wr_valid = 1'b0;
    logic [15:0]   I_wr_data = 16'h0000;
    logic          O_wr_ready;
    logic          I_rd_en = 1'b0;
    logic          I_flush = 1'b0;
    logic          I_clr_err = 1'b0;
    logic [4:0]    O_red;
    logic [5:0]    O_green;
    logic [4:0]    O_blue;
    logic [AW:0]   O_level;
    logic          O_empty;
    logic          O_underflow;

    always #5 I_clk = ~I_clk;

    vga_pixel_fifo #(.P_DEPTH(DEPTH), .P_ADDR_W(AW)) dut (
        .I_clk       (I_clk),
        .I_rst_n     (I_rst_n),
        .I_wr_valid  (I_wr_valid),
        .I_wr_data   (I_wr_data),
        .O_wr_ready  (O_wr_ready),
        .I_rd_en     (I_rd_en),
        .I_flush     (I_flush),
        .I_clr_err   (I_clr_err),
        .O_red       (O_red),
        .O_green     (O_green),
        .O_blue      (O_blue),
        .O_level     (O_level),
        .O_empty     (O_empty),
        .O_underflow (O_underflow)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a queue of stored pixels plus the visible output state.
    logic [15:0] q[$];
    logic [15:0] m_pix = 16'h0000;
    logic        m_uf = 1'b0;
    logic        m_rdy_en = 1'b0;
    logic        last_rdy;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        rd;
        logic        fl;
        logic        clr;
        logic        e_rdy;
        logic [15:0] e_pix;
        int          e_lvl;
        logic        e_uf;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_out();
        chk("red",       int'(O_red),   int'(m_pix[15:11]));
        chk("green",     int'(O_green), int'(m_pix[10:5]));
        chk("blue",      int'(O_blue),  int'(m_pix[4:0]));
        chk("level",     int'(O_level), q.size());
        chk("empty",     int'(O_empty), int'(q.size() == 0));
        chk("underflow", int'(O_underflow), int'(m_uf));
    endtask

    // One clock of stimulus: drive, check ready, advance model, clock, check outputs.
    task automatic cyc(input logic v, input logic [15:0] d, input logic rd,
                       input logic fl, input logic clr);
        logic rdy;
        logic uf_set;
        I_wr_valid = v;
        I_wr_data  = d;
        I_rd_en    = rd;
        I_flush    = fl;
        I_clr_err  = clr;
        #1;
        rdy = m_rdy_en && (q.size() != DEPTH) && !fl;
        last_rdy = O_wr_ready;
        chk("wr_ready", int'(O_wr_ready), int'(rdy));
        uf_set = 1'b0;
        if (fl) begin
            q.delete();
            m_pix = 16'h0000;
        end else if (rd) begin
            if (q.size() == 0) begin
                m_pix  = 16'h0000;
                uf_set = 1'b1;
            end else begin
                m_pix = q.pop_front();
            end
        end else begin
            m_pix = 16'h0000;
        end
        if (v && rdy) q.push_back(d);
        if (uf_set) m_uf = 1'b1;
        else if (clr) m_uf = 1'b0;
        @(posedge I_clk);
        #1;
        m_rdy_en = 1'b1;
        chk_out();
    endtask

    task automatic idle();
        cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset away from the clock edge, then release and recovery.
    task automatic do_reset();
        #3;
        I_rst_n = 1'b0;
        #1;
        chk("rst_red",   int'(O_red), 0);
        chk("rst_green", int'(O_green), 0);
        chk("rst_blue",  int'(O_blue), 0);
        chk("rst_level", int'(O_level), 0);
        chk("rst_empty", int'(O_empty), 1);
        chk("rst_ready", int'(O_wr_ready), 0);
        chk("rst_uf",    int'(O_underflow), 0);
        q.delete();
        m_pix = 16'h0000;
        m_uf = 1'b0;
        m_rdy_en = 1'b0;
        I_wr_valid = 1'b0;
        I_rd_en = 1'b0;
        I_flush = 1'b0;
        I_clr_err = 1'b0;
        repeat (2) @(posedge I_clk);
        #1;
        chk("rst_hold_ready", int'(O_wr_ready), 0);
        I_rst_n = 1'b1;
        idle();
        chk("rst_release_ready", int'(O_wr_ready), 1);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 16'hF800, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1, 1'b0};
        tbl[1]  = '{1'b1, 16'h07E0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hF800, 1, 1'b0};
        tbl[2]  = '{1'b1, 16'h001F, 1'b1, 1'b0, 1'b0, 1'b1, 16'h07E0, 1, 1'b0};
        tbl[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h001F, 0, 1'b0};
        tbl[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 0, 1'b1};
        tbl[5]  = '{1'b1, 16'hABCD, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1, 1'b1};
        tbl[6]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1, 1'b0};
        tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'hABCD, 0, 1'b0};
        tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 0, 1'b1};
        tbl[9]  = '{1'b1, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 1'b1};
        tbl[10] = '{1'b1, 16'h5555, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1, 1'b0};
        tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h5555, 0, 1'b0};

        @(posedge I_clk);
        #1;
        do_reset();

        // Directed vectors from a freshly reset FIFO.
        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].rd, tbl[i].fl, tbl[i].clr);
            chk($sformatf("tbl%0d_ready", i), int'(last_rdy), int'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_pix", i), int'({O_red, O_green, O_blue}), int'(tbl[i].e_pix));
            chk($sformatf("tbl%0d_level", i), int'(O_level), tbl[i].e_lvl);
            chk($sformatf("tbl%0d_uf", i), int'(O_underflow), int'(tbl[i].e_uf));
        end

        // Fill to full, refuse the extra word, then pop at full while offering one more.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
        chk("fill_level", int'(O_level), 1024);
        chk("fill_ready", int'(O_wr_ready), 0);
        cyc(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        chk("overfill_ready", int'(last_rdy), 0);
        chk("overfill_level", int'(O_level), 1024);
        cyc(1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b0);
        chk("full_rdwr_level", int'(O_level), 1023);
        chk("full_rdwr_pix", int'({O_red, O_green, O_blue}), 0);
        for (int i = 1; i < DEPTH; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("drain_last_pix", int'({O_red, O_green, O_blue}), 1023);
        chk("drain_empty", int'(O_empty), 1);

        // Second full pass exercises pointer wrap.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

        // Underflow is sticky until cleared.
        cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("uf_set", int'(O_underflow), 1);
        idle();
        chk("uf_hold", int'(O_underflow), 1);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        chk("uf_clr", int'(O_underflow), 0);

        // Simultaneous write and read at level 5.
        for (int i = 0; i < 5; i++) cyc(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h7777, 1'b1, 1'b0, 1'b0);
        chk("sim_level", int'(O_level), 5);

        // Flush at level 300 with concurrent write and read; underflow left set.
        cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
        chk("pre_flush_level", int'(O_level), 300);
        cyc(1'b1, 16'h4321, 1'b1, 1'b1, 1'b0);
        chk("flush_ready", int'(last_rdy), 0);
        chk("flush_level", int'(O_level), 0);
        chk("flush_pix", int'({O_red, O_green, O_blue}), 0);
        chk("flush_uf", int'(O_underflow), 1);

        // Randomized traffic in phases with different producer/consumer biases.
        for (int ph = 0; ph < 6; ph++) begin
            int pv;
            int prd;
            pv  = (ph % 3 == 0) ? 90 : (ph % 3 == 1) ? 20 : 55;
            prd = (ph % 3 == 0) ? 15 : (ph % 3 == 1) ? 85 : 50;
            for (int i = 0; i < 500; i++) begin
                cyc(1'($urandom_range(0, 99) < pv), 16'($urandom),
                    1'($urandom_range(0, 99) < prd),
                    1'($urandom_range(0, 199) == 0),
                    1'($urandom_range(0, 29) == 0));
            end
        end

        // Reset in the middle of traffic.
        for (int i = 0; i < 20; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
        I_wr_valid = 1'b1;
        I_rd_en = 1'b1;
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
